// File: rtl/sm_add32_seq_pkg.sv
// Shared types and constants for the sequential sign-magnitude adder.
// The FSM state enum, slice geometry and sign-magnitude field positions.
package sm_add32_seq_pkg;

    localparam int DATA_W     = 32;
    localparam int SLICE_W    = 4;
    localparam int NUM_SLICES = 8;
    localparam int IDX_W      = 3;
    localparam int SIGN_BIT   = 31;
    localparam int MAG_W      = 31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_CALC = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/sm_add32_seq_slice4.sv
// sm_slice4: one 4-bit add or subtract step with carry/borrow in and out.
// In subtract mode cin/cout are borrows.
module sm_slice4
    import sm_add32_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    input  logic               sub,
    output logic [SLICE_W-1:0] s,
    output logic               cout
);

    logic [SLICE_W:0] res;

    // The fifth bit is the carry out when adding and the borrow out when subtracting.
    always_comb begin
        if (sub) begin
            res = {1'b0, a} - {1'b0, b} - {{SLICE_W{1'b0}}, cin};
        end else begin
            res = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
        end
    end

    assign s    = res[SLICE_W-1:0];
    assign cout = res[SLICE_W];

endmodule

// File: rtl/sm_add32_seq.sv
// Sequential 32-bit sign-magnitude adder: compare, then eight 4-bit slices, then hold the result.
// Optional macro ADD_DEBUG_EN adds a debug[31:0] port exposing state, slice index and carry.
module sm_add32_seq
    import sm_add32_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] sum,
    output logic              ovf
`ifdef ADD_DEBUG_EN
    ,
    output logic [DATA_W-1:0] debug
`endif
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // in_ready is 1 only in IDLE; out_valid is 1 only in DONE once the result is loaded.

    state_e              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   sum_q, sum_d;
    logic                ovf_q, ovf_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic                s1_q, s1_d;
    logic                s2_q, s2_d;
    logic                sign_q, sign_d;
    logic                sub_q, sub_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                carry_q, carry_d;

    logic [SLICE_W-1:0]  slice_s;
    logic                slice_cout;
    logic [MAG_W-1:0]    mag;

    // Operands shift right each CALC cycle, so the active slice is always the low nibble.
    sm_slice4 u_slice (
        .a    (a_q[SLICE_W-1:0]),
        .b    (b_q[SLICE_W-1:0]),
        .cin  (carry_q),
        .sub  (sub_q),
        .s    (slice_s),
        .cout (slice_cout)
    );

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        ovf_d       = ovf_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        s1_d        = s1_q;
        s2_d        = s2_q;
        sign_d      = sign_q;
        sub_d       = sub_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        mag         = acc_q[MAG_W-1:0];

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d        = {1'b0, op1[MAG_W-1:0]};
                    b_d        = {1'b0, op2[MAG_W-1:0]};
                    s1_d       = op1[SIGN_BIT];
                    s2_d       = op2[SIGN_BIT];
                    in_ready_d = 1'b0;
                    state_d    = ST_CMP;
                end
            end
            ST_CMP: begin
                sub_d   = s1_q ^ s2_q;
                sign_d  = s1_q;
                // Keep the larger magnitude in a so subtraction never borrows out of the top.
                if ((s1_q != s2_q) && (b_q[MAG_W-1:0] > a_q[MAG_W-1:0])) begin
                    a_d    = b_q;
                    b_d    = a_q;
                    sign_d = s2_q;
                end
                idx_d   = '0;
                carry_d = 1'b0;
                acc_d   = '0;
                state_d = ST_CALC;
            end
            ST_CALC: begin
                a_d     = a_q >> SLICE_W;
                b_d     = b_q >> SLICE_W;
                acc_d   = {slice_s, acc_q[DATA_W-1:SLICE_W]};
                carry_d = slice_cout;
                idx_d   = idx_q + 3'd1;
                if (idx_q == IDX_W'(NUM_SLICES - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!out_valid_q) begin
                    // Bit 31 of the zero-padded sum is the carry out of magnitude bit 30.
                    ovf_d       = !sub_q && acc_q[DATA_W-1];
                    sum_d       = (mag == '0) ? '0 : {sign_q, mag};
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            ovf_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            sign_q      <= 1'b0;
            sub_q       <= 1'b0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            ovf_q       <= ovf_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            sign_q      <= sign_d;
            sub_q       <= sub_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign ovf       = ovf_q;

`ifdef ADD_DEBUG_EN
    assign debug = {state_q, idx_q, carry_q, 26'b0};
`endif

endmodule

// File: tb/tb_sm_add32_seq.sv
// Self-checking bench for sm_add32_seq: directed vector table, stall and reset
// sequences, and random operands checked against a signed-arithmetic reference model.
module tb_sm_add32_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        ovf;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
        logic        ovf;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    sm_add32_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .ovf       (ovf)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: sign-magnitude operands as signed integers, add, then re-encode.
    function automatic logic [32:0] ref_model(input logic [31:0] a, input logic [31:0] b);
        longint va, vb, r, m;
        longint lim;
        logic   o;
        logic   neg;
        lim = 64'h80000000;
        va  = longint'(a[30:0]);
        vb  = longint'(b[30:0]);
        if (a[31]) va = -va;
        if (b[31]) vb = -vb;
        r   = va + vb;
        neg = (r < 0);
        m   = neg ? -r : r;
        o   = (m >= lim);
        m   = m % lim;
        if (m == 0) return {o, 32'h0};
        return {o, neg, m[30:0]};
    endfunction

    // One complete transaction: issue, measure latency, optionally stall, then accept.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int hold, input bit poke);
        logic [32:0] exp;
        int lat;
        exp_q.push_back(ref_model(a, b));
        @(negedge clk);
        check("in_ready_before_issue", in_ready, 1);
        in_valid = 1'b1;
        op1 = a;
        op2 = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op1 = $urandom;
        op2 = $urandom;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, 10);
        exp = exp_q.pop_front();
        if (out_valid) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("stall_out_valid", out_valid, 1);
                check("stall_in_ready", in_ready, 0);
                check("stall_sum", sum, exp[31:0]);
                check("stall_ovf", ovf, exp[32]);
                if (poke) begin
                    in_valid = 1'b1;
                    op1 = $urandom;
                    op2 = $urandom;
                end
                @(posedge clk);
                #1;
                in_valid = 1'b0;
            end
            @(negedge clk);
            check("handshake_in_ready", in_ready, 0);
            check("sum", sum, exp[31:0]);
            check("ovf", ovf, exp[32]);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            check("out_valid_after_accept", out_valid, 0);
            check("in_ready_after_accept", in_ready, 1);
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [32:0] mexp;

        vecs[0] = '{32'h00000004, 32'h00000007, 32'h0000000B, 1'b0};
        vecs[1] = '{32'h00000004, 32'h80000007, 32'h80000003, 1'b0};
        vecs[2] = '{32'h80000004, 32'h00000007, 32'h00000003, 1'b0};
        vecs[3] = '{32'h80000007, 32'h00000007, 32'h00000000, 1'b0};
        vecs[4] = '{32'h80000000, 32'h80000000, 32'h00000000, 1'b0};
        vecs[5] = '{32'h7FFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
        vecs[6] = '{32'hFFFFFFFF, 32'h80000001, 32'h00000000, 1'b1};
        vecs[7] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFE, 1'b1};
        vecs[8] = '{32'h80001234, 32'h80000F00, 32'h80002134, 1'b0};
        vecs[9] = '{32'h00000000, 32'h80000005, 32'h80000005, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op1       = '0;
        op2       = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_sum", sum, 0);
        check("reset_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table: confirm the model agrees with the hand values, then run the DUT.
        for (int i = 0; i < 10; i++) begin
            mexp = ref_model(vecs[i].a, vecs[i].b);
            if (mexp !== {vecs[i].ovf, vecs[i].sum})
                $display("note: reference disagrees with table entry %0d", i);
            exp_q.push_back({vecs[i].ovf, vecs[i].sum});
            exp_q.push_back(mexp);
            void'(exp_q.pop_back());
            void'(exp_q.pop_back());
            do_op(vecs[i].a, vecs[i].b, i % 3, 1'b0);
        end

        // Result held for 5 cycles with in_valid pulses that must be ignored.
        do_op(32'h00000123, 32'h80000456, 5, 1'b1);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            check("no_spurious_result", out_valid, 0);
        end

        // Reset while slice 4 is in progress abandons the operation.
        @(negedge clk);
        in_valid = 1'b1;
        op1 = 32'h00000ABC;
        op2 = 32'h00000DEF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_reset_out_valid", out_valid, 0);
        check("mid_reset_sum", sum, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            check("abandoned_no_result", out_valid, 0);
        end
        check("idle_after_reset", in_ready, 1);
        do_op(32'h00000004, 32'h00000007, 0, 1'b0);

        // Random operands, with some small and equal magnitudes to hit zero results.
        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 1) begin
                ra[30:0] = 31'($urandom_range(0, 20));
                rb[30:0] = 31'($urandom_range(0, 20));
            end
            if (i % 5 == 2) rb[30:0] = ra[30:0];
            do_op(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sm_add32_seq.md
SM_ADD32_SEQ -- requirements
Module: sm_add32_seq

Interface
REQ-001 SHALL have ports: clk in 1 system clock, rising edge; rst_n in 1 asynchronous active-low reset.
REQ-002 SHALL have ports: in_valid in 1 operands present; in_ready out 1 block can accept operands; op1 in 32 addend, sign-magnitude (bit31 sign, bits30:0 magnitude); op2 in 32 addend, same encoding.
REQ-003 SHALL have ports: out_valid out 1 result present; out_ready in 1 consumer accepts result; sum out 32 sign-magnitude result; ovf out 1 magnitude overflow flag.
REQ-004 SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.

Function
REQ-005 SHALL use the four-state FSM IDLE, CMP, CALC, DONE.
REQ-006 SHALL hold in_ready=1 only in IDLE; in_valid&in_ready at an edge SHALL register op1/op2 and go to CMP.
REQ-007 CMP (1 cycle) SHALL select the operation: signs equal -> add magnitudes, result sign = op1 sign; signs differ -> subtract the smaller magnitude from the larger, result sign = sign of the larger.
REQ-008 CALC SHALL process the 31-bit magnitude (zero-padded to 32) in 4-bit slices, LSB slice first, one slice per cycle, with the carry/borrow registered between slices: 8 cycles, then DONE.
REQ-009 Latency SHALL be fixed: out_valid rises 10 edges after the accepting edge, independent of operand values.
REQ-010 In DONE, out_valid=1 and sum/ovf SHALL be stable until out_valid&out_ready; then return to IDLE; in_ready SHALL be 0 in the cycle of that handshake (no same-cycle reissue).
REQ-011 ovf SHALL be 1 only when an add produces a carry out of magnitude bit 30; sum magnitude then = low 31 bits (wrap), sign as REQ-007.
REQ-012 Equal magnitudes with differing signs SHALL give sum=32'h00000000 (+0), ovf=0.
REQ-013 Inputs of -0 (32'h80000000) SHALL be treated as magnitude 0; a zero-magnitude result SHALL always be +0.
REQ-014 in_valid in non-IDLE states SHALL be ignored; out_ready outside DONE SHALL be ignored.
REQ-015 sum and ovf SHALL be driven from registers only.

Reset
REQ-016 On rst_n=0, state=IDLE, in_ready=1 after release, out_valid=0, sum=0, ovf=0, and all slice/carry registers cleared, asynchronously.
REQ-017 Reset during CMP/CALC/DONE SHALL abandon the operation with no result emitted.

Configuration
REQ-018 With ADD_DEBUG_EN defined, the block SHALL add output debug[31:0] = {state[1:0], slice index[2:0], carry/borrow bit, 26'b0}, combinational from registers; without it, the port and its logic SHALL be absent and behaviour is otherwise identical.

Structure
REQ-019 A shared package SHALL hold the FSM state enum, SLICE_W=4, NUM_SLICES=8, and the sign-magnitude field constants (SIGN_BIT=31, MAG_W=31).
REQ-020 The per-slice 4-bit add/subtract with carry/borrow in/out SHALL be a sub-module named sm_slice4.

Verification
REQ-021 op1=32'h00000004, op2=32'h00000007 -> sum=32'h0000000B, ovf=0, out_valid 10 edges after accept.
REQ-022 op1=32'h00000004, op2=32'h80000007 -> sum=32'h80000003; op1=32'h80000004, op2=32'h00000007 -> sum=32'h00000003.
REQ-023 op1=32'h80000007, op2=32'h00000007 -> sum=32'h00000000; op1=32'h80000000, op2=32'h80000000 -> sum=32'h00000000.
REQ-024 op1=32'h7FFFFFFF, op2=32'h00000001 -> sum=32'h00000000, ovf=1; op1=32'hFFFFFFFF, op2=32'h80000001 -> sum=32'h80000000 normalised to 32'h00000000, ovf=1.
REQ-025 Hold out_ready=0 for 5 cycles in DONE -> sum/out_valid stable and in_ready=0 throughout; in_valid pulses in that window are not accepted.
REQ-026 Assert rst_n=0 during CALC slice 4 -> out_valid stays 0, state IDLE; the next operation, 4+7, yields 32'h0000000B.
